// File: rtl/deskew_ctrl.sv
// deskew_ctrl: lane-alignment controller for the deskew datapath.
// Drives NUM_LANES per-lane FIFOs through write / read / sync-clear strobes.
// Each lane's writes are gated until its alignment marker arrives; the
// marker-to-marker spread is measured, and once every lane has marked,
// lock-step reads are released so all FIFO outputs present the same word.
//
// Ports:
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   enable_i            run alignment; low returns the block to IDLE
//   lane_valid_i/data_i per-lane input words (lane i at [i*DATA_WIDTH +: DATA_WIDTH])
//   fifo_empty_i/full_i per-lane FIFO flags
//   out_ready_i         downstream accepts an aligned word set
//   fifo_wr_en_o        per-lane write enables (combinational)
//   fifo_rd_en_o        per-lane read enables (combinational, all bits equal)
//   fifo_sclr_o         per-lane sync clears (registered, all bits equal)
//   out_valid_o         FIFO data_out valid (read strobe delayed one cycle)
//   aligned_o           high while locked
//   align_err_o         one-cycle error pulse
//   skew_max_o          first-to-last marker spread at the last lock

// Per-lane marker detect and write gating.
module deskew_lane #(
  parameter int                    DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] MARKER     = 8'hBC
) (
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  seen_i,
  input  logic                  hunt_i,     // HUNT or WAIT_ALL
  input  logic                  aligned_i,
  output logic                  mark_o,
  output logic                  wr_en_o
);
  assign mark_o = valid_i && (data_i == MARKER);
  // While hunting, the marker itself is the first word written.
  assign wr_en_o = aligned_i ? valid_i
                             : (hunt_i && valid_i && (seen_i || mark_o));
endmodule

module deskew_ctrl #(
  parameter int                    NUM_LANES  = 4,
  parameter int                    DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] MARKER     = 8'hBC,
  parameter int                    MAX_SKEW   = 16,
  parameter int                    SKEW_WIDTH = 5
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            enable_i,
  input  logic [NUM_LANES-1:0]            lane_valid_i,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] lane_data_i,
  input  logic [NUM_LANES-1:0]            fifo_empty_i,
  input  logic [NUM_LANES-1:0]            fifo_full_i,
  input  logic                            out_ready_i,
  output logic [NUM_LANES-1:0]            fifo_wr_en_o,
  output logic [NUM_LANES-1:0]            fifo_rd_en_o,
  output logic [NUM_LANES-1:0]            fifo_sclr_o,
  output logic                            out_valid_o,
  output logic                            aligned_o,
  output logic                            align_err_o,
  output logic [SKEW_WIDTH-1:0]           skew_max_o
);
  localparam logic [SKEW_WIDTH-1:0] SKEW_LIM = SKEW_WIDTH'(MAX_SKEW);

  typedef enum logic [2:0] {
    S_IDLE, S_FLUSH, S_HUNT, S_WAIT_ALL, S_ALIGNED
  } state_e;

  state_e                 state_q;
  logic [NUM_LANES-1:0]   seen_q, seen_d;
  logic [SKEW_WIDTH-1:0]  skew_cnt_q, skew_max_q;
  logic                   sclr_q, out_valid_q, align_err_q;

  logic [NUM_LANES-1:0]   mark, wr_en;
  logic                   hunting, locked, rd;

  assign hunting = (state_q == S_HUNT) || (state_q == S_WAIT_ALL);
  assign locked  = (state_q == S_ALIGNED);

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    deskew_lane #(.DATA_WIDTH(DATA_WIDTH), .MARKER(MARKER)) u_lane (
      .valid_i   (lane_valid_i[g]),
      .data_i    (lane_data_i[g*DATA_WIDTH +: DATA_WIDTH]),
      .seen_i    (seen_q[g]),
      .hunt_i    (hunting),
      .aligned_i (locked),
      .mark_o    (mark[g]),
      .wr_en_o   (wr_en[g])
    );
  end

  assign seen_d = seen_q | mark;
  // Lock-step read: only when every lane has a word to give.
  assign rd     = locked && out_ready_i && !(|fifo_empty_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      seen_q      <= '0;
      skew_cnt_q  <= '0;
      skew_max_q  <= '0;
      sclr_q      <= 1'b0;
      out_valid_q <= 1'b0;
      align_err_q <= 1'b0;
    end else begin
      sclr_q      <= 1'b0;
      align_err_q <= 1'b0;
      out_valid_q <= rd;
      if (!enable_i && state_q != S_IDLE) begin
        state_q <= S_IDLE;
        sclr_q  <= 1'b1;
      end else begin
        case (state_q)
          S_IDLE: if (enable_i) begin
            state_q <= S_FLUSH;
            sclr_q  <= 1'b1;
          end
          S_FLUSH: begin
            seen_q     <= '0;
            skew_cnt_q <= '0;
            state_q    <= S_HUNT;
          end
          S_HUNT, S_WAIT_ALL: begin
            if (|(wr_en & fifo_full_i)) begin
              // Overflow while hunting: the captured alignment is unusable.
              state_q     <= S_FLUSH;
              sclr_q      <= 1'b1;
              align_err_q <= 1'b1;
            end else begin
              seen_q <= seen_d;
              if (&seen_d) begin
                // Completion wins over timeout in the same cycle.
                skew_max_q <= (state_q == S_HUNT) ? '0 : skew_cnt_q;
                state_q    <= S_ALIGNED;
              end else if (state_q == S_HUNT) begin
                if (|mark) begin
                  skew_cnt_q <= SKEW_WIDTH'(1);
                  state_q    <= S_WAIT_ALL;
                end
              end else if (skew_cnt_q == SKEW_LIM) begin
                state_q     <= S_FLUSH;
                sclr_q      <= 1'b1;
                align_err_q <= 1'b1;
              end else begin
                skew_cnt_q <= skew_cnt_q + SKEW_WIDTH'(1);
              end
            end
          end
          S_ALIGNED: if (|fifo_full_i) begin
            state_q     <= S_FLUSH;
            sclr_q      <= 1'b1;
            align_err_q <= 1'b1;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign fifo_wr_en_o = wr_en;
  assign fifo_rd_en_o = {NUM_LANES{rd}};
  assign fifo_sclr_o  = {NUM_LANES{sclr_q}};
  assign out_valid_o  = out_valid_q;
  assign aligned_o    = locked;
  assign align_err_o  = align_err_q;
  assign skew_max_o   = skew_max_q;
endmodule
